// File: rtl/if_id_queue_if.sv
// Fetch/decode bundle for the instruction prefetch queue.
//
// Handshake: the fetch side offers {pcF, instrF} with validF and treats
// !stallF as ready, so an entry is accepted when validF && !stallF && !flushD.
// The decode side sees validD as valid and !stallD as ready, so the head
// entry is consumed when validD && !stallD && !flushD. stallF and validD come
// only from registered state, never combinationally from the other side.
interface if_id_queue_if #(
  parameter int AW = 2
);
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        validF;
  logic        stallD;
  logic        flushD;
  logic        stallF;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;
  logic [AW:0] countD;

  // Pipeline side: drives fetch data and decode control, observes the queue.
  modport master (
    output pcF, instrF, validF, stallD, flushD,
    input  stallF, pcD, instrD, validD, countD
  );

  // Queue side.
  modport slave (
    input  pcF, instrF, validF, stallD, flushD,
    output stallF, pcD, instrD, validD, countD
  );
endinterface

// File: rtl/if_id_queue.sv
// Instruction prefetch queue replacing the IF/ID register. Holds up to DEPTH
// {pc, instr} pairs, presents the oldest to decode, stalls fetch when full and
// discards everything on a redirect. No fall-through: a pushed entry becomes
// visible one cycle later, like a plain pipeline register.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          not_empty;
  logic          push;
  logic          pop;

  // Status flags from registered occupancy only; a pop never frees a slot for
  // a same-cycle push, which keeps stallF independent of stallD.
  always_comb begin
    full      = (count == FULL_COUNT);
    not_empty = (count != '0);
    push      = q.validF && !full && !q.flushD;
    pop       = not_empty && !q.stallD && !q.flushD;
  end

  // Pointer and occupancy state; flush empties the queue, reset dominates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (q.flushD) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Entry storage; contents are don't-care until written so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {q.pcF, q.instrF};
  end

  // Head presentation: NOP (all zero) when empty, oldest entry otherwise.
  always_comb begin
    q.validD = not_empty;
    q.stallF = full;
    q.countD = count;
    q.pcD    = '0;
    q.instrD = '0;
    if (not_empty) begin
      q.pcD    = mem[rptr][63:32];
      q.instrD = mem[rptr][31:0];
    end
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction prefetch queue between the fetch stage and decode. It replaces the bare IF/ID register.
- Buffers up to DEPTH fetched {pc, instr} pairs, so a decode stall does not immediately freeze fetch.
- Presents the oldest entry to decode as pcD/instrD/validD.
- Back-pressures fetch via stallF when full.
- Discards all contents on a branch/jump redirect (flushD).

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pcF  input  32  pc of the instruction fetched this cycle.
- instrF  input  32  instruction word fetched this cycle.
- validF  input  1  pcF/instrF carry a real fetch this cycle.
- stallD  input  1  decode holds its current instruction; no pop this cycle.
- flushD  input  1  redirect; discard all queued entries.
- stallF  output  1  queue full; fetch must hold pc.
- pcD  output  32  pc of head entry.
- instrD  output  32  instruction of head entry.
- validD  output  1  head entry is valid (queue non-empty).
- countD  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit register array {pc, instr}, with AW-bit write pointer wptr, AW-bit read pointer rptr, and an AW+1-bit count.
- Reset (rst=0, asynchronous): wptr=0, rptr=0, count=0. Storage contents need no reset.
  - Outputs during and immediately after reset: validD=0, pcD=0, instrD=0, stallF=0, countD=0.
- push = validF && (count != DEPTH) && !flushD.
- pop = validD && !stallD && !flushD.
- On push: mem[wptr] <= {pcF, instrF}; wptr <= wptr+1, wrapping modulo DEPTH through natural AW-bit overflow.
- On pop: rptr <= rptr+1, wrapping the same way.
- count <= count + push - pop:
  - simultaneous push and pop leaves count unchanged;
  - push and pop may both happen when 0 < count < DEPTH.
- Full (count==DEPTH):
  - stallF=1, and any validF is ignored. Fetch must hold pcF/instrF stable and re-present it.
  - A pop in the same cycle does NOT enable a push; there is no bypass, which keeps stallF free of a combinational path from stallD.
- stallF is a pure function of registered count: stallF = (count==DEPTH).
- Empty (count==0):
  - validD=0, pcD=0, instrD=0 (NOP).
  - There is no fall-through: a push at edge N becomes visible on the outputs after edge N. Latency is 1 cycle, the same as a pipeline register.
- Non-empty: validD=1, pcD/instrD = mem[rptr], read combinationally from the registered array.
- Decode stall: with stallD=1, the head entry is held and outputs are unchanged; pushes continue until full.
- Flush (flushD=1, synchronous):
  - wptr <= 0, rptr <= 0, count <= 0.
  - Any same-cycle push and pop are dropped; flush dominates validF and stallD.
  - The next cycle shows validD=0 and stallF=0.
- flushD and rst asserted together: reset dominates, with identical end state.
- Reset asserted mid-operation clears state immediately (asynchronously), regardless of clk.
- countD = count, registered.

Test Plan:
- Reset: hold rst=0 with random inputs -> validD=0, pcD=0, instrD=0, stallF=0, countD=0. Release; first push of pc=0x00003000, instr=0x3C010001 -> next cycle validD=1, pcD=0x00003000, instrD=0x3C010001.
- Fill: stallD=1, push pcs 0x3000,0x3004,0x3008,0x300C -> countD=4, stallF=1. A 5th validF with pc=0x3010 is ignored. stallD=0 for one cycle -> pcD=0x3004, countD=3, stallF=0.
- Streaming: count=2, validF=1, stallD=0 every cycle for 10 cycles -> countD stays 2. pcD sequence lags the pcF sequence by 2 entries, in order with no gaps.
- Wrap-around: push/pop 9 entries with pcs 0x3000+4k across pointer wrap -> decode sees all 9 in order, with no duplicates or drops.
- Flush: count=3, flushD=1 together with validF=1 and pc=0x4000 -> next cycle validD=0, countD=0, stallF=0. A following push of pc=0x4000 appears as pcD=0x4000.
- Reset mid-operation: count=3, drop rst between clock edges -> validD=0 and countD=0 immediately, before the next edge.
